// File: rtl/selector_addr_seq_pkg.sv
// Shared types and helpers for the selector address sequencer and selector bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package selector_addr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic int addr_width(input int size);
        return (size < 2) ? 1 : $clog2(size);
    endfunction

    // Lane i occupies bits [lane_lsb(i, aw) +: aw]; the selector bank unpacks with the same rule.
    function automatic int lane_lsb(input int lane, input int aw);
        return lane * aw;
    endfunction

endpackage

// File: rtl/selector_addr_seq_if.sv
// Job-control and beat-output bundle between the sequencer and the selector stage.
// Latency: n/a (wiring only).
// Backpressure: consumer drives ready; sequencer holds valid and N_flat until accepted.
interface selector_addr_seq_if #(
    parameter int SIZE = 16,
    parameter int K    = 4,
    parameter int BW   = 8
);
    localparam int AW = selector_addr_seq_pkg::addr_width(SIZE);

    logic            start;
    logic [AW-1:0]   base;
    logic [AW-1:0]   stride;
    logic [BW-1:0]   num_beats;
    logic            ready;
    logic            valid;
    logic [AW*K-1:0] N_flat;
    logic            busy;
    logic            done;
`ifdef SELADDR_LAST_EN
    logic            last;
`endif

    modport master (
        input  start, base, stride, num_beats, ready,
        output valid, N_flat, busy, done
`ifdef SELADDR_LAST_EN
        , output last
`endif
    );

    modport slave (
        output start, base, stride, num_beats, ready,
        input  valid, N_flat, busy, done
`ifdef SELADDR_LAST_EN
        , input last
`endif
    );

endinterface

// File: rtl/selector_lane_addr.sv
// Packs K lane addresses: lane i = cur + i*stride, truncated to AW bits (mod SIZE).
// Latency: combinational.
// Backpressure: none.
module selector_lane_addr
    import selector_addr_seq_pkg::*;
#(
    parameter int AW = 4,
    parameter int K  = 4
) (
    input  logic [AW-1:0]   cur,
    input  logic [AW-1:0]   stride,
    output logic [AW*K-1:0] n_flat
);

    for (genvar i = 0; i < K; i++) begin : g_lane
        localparam logic [AW-1:0] IDX = AW'(i);
        assign n_flat[lane_lsb(i, AW) +: AW] = cur + IDX * stride;
    end

endmodule

// File: rtl/selector_addr_seq.sv
// Strided wrap-around address sequencer feeding K lanes per beat; SELADDR_LAST_EN adds a last-beat flag.
// Latency: first beat the cycle after start is sampled, then one beat per accepted cycle; done the cycle after the final beat.
// Backpressure: valid/ready; with ready low the beat, address and counters hold unchanged.
module selector_addr_seq
    import selector_addr_seq_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int K    = 4,
    parameter int BW   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    selector_addr_seq_if.master bus
);

    localparam int            AW     = addr_width(SIZE);
    localparam logic [AW-1:0] K_STEP = AW'(K);

    seq_state_t      state;
    logic [AW-1:0]   cur;
    logic [AW-1:0]   stride_q;
    logic [BW-1:0]   beat_cnt;
    logic            valid_q;
    logic            done_q;
    logic            busy_q;
    logic [AW*K-1:0] n_flat;

    // Addresses derive only from registers, so no input reaches N_flat combinationally.
    selector_lane_addr #(
        .AW (AW),
        .K  (K)
    ) u_lane_addr (
        .cur    (cur),
        .stride (stride_q),
        .n_flat (n_flat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur      <= '0;
            stride_q <= '0;
            beat_cnt <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        cur      <= bus.base;
                        stride_q <= bus.stride;
                        beat_cnt <= bus.num_beats;
                        busy_q   <= 1'b1;
                        if (bus.num_beats != '0) begin
                            valid_q <= 1'b1;
                            state   <= ST_RUN;
                        end else begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (valid_q && bus.ready) begin
                        cur      <= cur + K_STEP * stride_q;
                        beat_cnt <= beat_cnt - BW'(1);
                        if (beat_cnt == BW'(1)) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.valid  = valid_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.N_flat = n_flat;
`ifdef SELADDR_LAST_EN
    assign bus.last   = valid_q && (beat_cnt == BW'(1));
`endif

endmodule

// File: tb/tb_selector_addr_seq.sv
// Directed plus randomized jobs for selector_addr_seq, checked against an arithmetic address model.
// Builds with or without SELADDR_LAST_EN.
module tb_selector_addr_seq;
    import selector_addr_seq_pkg::*;

    localparam int SIZE = 16;
    localparam int K    = 4;
    localparam int BW   = 8;
    localparam int AW   = addr_width(SIZE);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    selector_addr_seq_if #(.SIZE(SIZE), .K(K), .BW(BW)) bus ();

    selector_addr_seq #(.SIZE(SIZE), .K(K), .BW(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Beat j of a job: lane i carries (base + (j*K + i)*stride) mod SIZE.
    function automatic logic [AW*K-1:0] model_beat(input int b, input int s, input int j);
        logic [AW*K-1:0] e;
        e = '0;
        for (int i = 0; i < K; i++)
            e[i*AW +: AW] = AW'((b + (j * K + i) * s) % SIZE);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag, input logic exp_done, input logic exp_busy);
        chk({tag, "_valid"}, 64'(bus.valid), 64'(0));
        chk({tag, "_done"},  64'(bus.done),  64'(exp_done));
        chk({tag, "_busy"},  64'(bus.busy),  64'(exp_busy));
`ifdef SELADDR_LAST_EN
        chk({tag, "_last"},  64'(bus.last),  64'(0));
`endif
    endtask

    // mode 0: ready always high; 1: random ready; 2: first beat stalled 3 cycles.
    task automatic run_job(input int b, input int s, input int n, input int mode, input bit glitch);
        int  j;
        int  stalls;
        int  cyc;
        bit  rdy;
        bus.base      = AW'(b);
        bus.stride    = AW'(s);
        bus.num_beats = BW'(n);
        bus.start     = 1'b1;
        bus.ready     = (mode == 0);
        step();
        bus.start     = 1'b0;
        // Parameters changing after start must not affect the running job.
        bus.base      = AW'($urandom);
        bus.stride    = AW'($urandom);
        bus.num_beats = BW'($urandom);
        j = 0; stalls = 0; cyc = 0;
        while (j < n && cyc < 200) begin
            chk("beat_valid", 64'(bus.valid), 64'(1));
            chk("beat_addr",  64'(bus.N_flat), 64'(model_beat(b, s, j)));
            chk("beat_busy",  64'(bus.busy), 64'(1));
            chk("beat_done",  64'(bus.done), 64'(0));
`ifdef SELADDR_LAST_EN
            chk("beat_last",  64'(bus.last), 64'(j == n - 1));
`endif
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
                default: rdy = !(j == 0 && stalls < 3);
            endcase
            if (glitch && $urandom_range(0, 1) == 1) begin
                bus.start     = 1'b1;
                bus.base      = AW'($urandom);
                bus.num_beats = BW'($urandom_range(1, 9));
            end
            bus.ready = rdy;
            step();
            bus.start = 1'b0;
            if (rdy) begin
                j++;
                stalls = 0;
            end else begin
                stalls++;
            end
            cyc++;
        end
        if (cyc >= 200) chk("job_timeout", 64'(cyc), 64'(0));
        chk_idle_outputs("end", 1'b1, 1'b1);
        step();
        chk_idle_outputs("post", 1'b0, 1'b0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base      = '0;
        bus.stride    = '0;
        bus.num_beats = '0;
        bus.ready     = 1'b0;
        #12;
        chk_idle_outputs("reset", 1'b0, 1'b0);
        chk("reset_nflat", 64'(bus.N_flat), 64'(0));
        #10 rst_n = 1'b1;
        step();
        chk_idle_outputs("idle", 1'b0, 1'b0);

        run_job(2, 1, 2, 0, 1'b0);
        chk("plain_b0", 64'(model_beat(2, 1, 0)), 64'h5432);
        run_job(14, 3, 2, 0, 1'b0);
        run_job(2, 1, 2, 2, 1'b0);
        run_job(7, 0, 3, 0, 1'b0);
        run_job(9, 5, 4, 1, 1'b0);
        run_job(3, 1, 0, 0, 1'b0);
        run_job(2, 1, 4, 0, 1'b1);
        run_job(11, 6, 5, 1, 1'b1);

        // Reset mid-job: outputs drop without a clock edge and no done follows.
        bus.base = AW'(2); bus.stride = AW'(1); bus.num_beats = BW'(5);
        bus.start = 1'b1; bus.ready = 1'b1;
        step();
        bus.start = 1'b0;
        chk("mid_valid", 64'(bus.valid), 64'(1));
        step();
        chk("mid_addr", 64'(bus.N_flat), 64'(model_beat(2, 1, 1)));
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("arst", 1'b0, 1'b0);
        chk("arst_nflat", 64'(bus.N_flat), 64'(0));
        step();
        step();
        chk_idle_outputs("arst_hold", 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        step();
        chk_idle_outputs("arst_rel", 1'b0, 1'b0);
        run_job(5, 2, 3, 0, 1'b0);

        repeat (25) begin
            run_job(int'($urandom_range(0, SIZE - 1)), int'($urandom_range(0, SIZE - 1)),
                    int'($urandom_range(0, 6)), 1, bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/selector_addr_seq.md
Name: selector_addr_seq

Overview:
- Upstream address sequencer for the K-lane multi-selector.
- Each beat it emits K packed lane addresses (N_flat) for the selector bank, stepping through a strided, wrap-around address pattern for a programmed number of beats.
- Uses a valid/ready handshake so the downstream selector stage can stall it.

Parameters:
- SIZE, 16, address range. Must be a power of two, ≥2. AW = $clog2(SIZE).
- K, 4, lanes per beat. Must match the selector bank's K.
- BW, 8, width of the beat counter; maximum 2^BW-1 beats per job.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- base  in  AW  lane-0 address of beat 0
- stride  in  AW  address step between adjacent lanes
- num_beats  in  BW  beats in the job
- ready  in  1  downstream accepts the current beat
- valid  out  1  N_flat holds a valid beat
- N_flat  out  AW*K  lane i at [i*AW +: AW]
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse at end of job

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all state is cleared immediately on assertion.
- Reset values:
  - state=IDLE; cur, stride_q and beat_cnt are 0.
  - valid=0, done=0, busy=0, N_flat=0.
- Lane address: lane i = (cur + i*stride_q) mod SIZE.
  - Computed combinationally from registers only; truncated to AW bits, so wrap is natural.
  - No combinational path from any input port to N_flat or valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - valid=0.
  - On start: latch cur<=base, stride_q<=stride, beat_cnt<=num_beats.
  - Next state is RUN if num_beats≠0, else DONE.
- RUN:
  - valid=1.
  - On valid&&ready: cur <= (cur + K*stride_q) mod SIZE and beat_cnt <= beat_cnt-1.
  - If beat_cnt==1 at acceptance, go to DONE.
  - While ready=0: cur, N_flat and valid hold exactly; the handshake never withdraws a beat.
- DONE:
  - done=1 for exactly one cycle, valid=0; then IDLE.
- Latency:
  - start sampled at edge t → first valid beat visible after edge t, i.e. in cycle t+1.
  - One beat per cycle when ready is held high.
  - done asserts in the cycle after the last accepted beat.
- Boundaries:
  - num_beats=0: no valid beat; done pulses in cycle t+1.
  - start while busy: ignored, and the latched parameters are unchanged.
  - stride=0: all lanes and all beats carry the same address; this is legal.
  - K*stride ≥ SIZE: wraps modulo SIZE; this is legal.
  - rst_n low mid-RUN: valid drops asynchronously and the job is abandoned; no done pulse.
  - base, stride and num_beats changing during RUN: no effect.

Optional Feature:
- Macro SELADDR_LAST_EN.
- Defined: adds output port last (1 bit).
  - last = valid && beat_cnt==1, marking the final beat of a job.
  - Reset value 0; it holds with the beat under backpressure.
- Undefined: no last port and no extra logic; the rest of the behaviour is identical.

Decomposition:
- Shared package:
  - State enum (IDLE/RUN/DONE).
  - AW derivation helper.
  - Lane-packing offset constant (lane i at i*AW), shared with the selector bank so packing stays consistent.
- One natural sub-module, selector_lane_addr: purely combinational, cur/stride → K packed addresses.
- FSM and counters stay in the top.

Test Plan:
- Reset, then base=2, stride=1, num_beats=2, ready=1 → beat0 lanes {2,3,4,5}, beat1 lanes {6,7,8,9}; done pulses the cycle after beat1; busy falls with it.
- Wrap case: base=14, stride=3, num_beats=2 → beat0 {14,1,4,7}, beat1 {10,13,0,3}.
- Backpressure: ready=0 for 3 cycles on beat0 → valid stays 1 and N_flat is held at {2,3,4,5}; beat1 appears only after ready=1.
- num_beats=0 with start → valid never asserts; done=1 in cycle t+1 only.
- start pulsed during RUN with different base → ignored; sequence unchanged.
- rst_n low while valid=1 → valid, busy and N_flat go to 0 without waiting for clk; the next start runs cleanly. With SELADDR_LAST_EN: last=1 only on the final beat of each job.
